// File: rtl/sram_like_responder_pkg.sv
// Shared definitions for the SRAM-like responder: transfer size encodings,
// default geometry and the memory write-enable helper.
package sram_like_responder_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_e;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_AW    = 16;

    // Reads must never disturb the memory, whatever the initiator left on req_wen.
    function automatic logic [3:0] mem_we_f(input logic wr, input logic [3:0] wen);
        logic [3:0] we_v;
        if (wr) begin
            we_v = wen;
        end else begin
            we_v = 4'b0000;
        end
        return we_v;
    endfunction

endpackage

// File: rtl/sram_like_responder_if.sv
// Request/response bus between the initiator and the responder, plus the
// synchronous single-port memory command port owned by the responder.
interface sram_like_responder_if #(
    parameter int AW = 16
);
    logic          req_en;
    logic          req_wr;
    logic [1:0]    req_size;
    logic [3:0]    req_wen;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          addr_stall;
    logic          resp_stall;
    logic          addr_ok;
    logic [31:0]   addr_ok_addr;
    logic          data_ok;
    logic [31:0]   rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  req_en, req_wr, req_size, req_wen, req_addr, req_wdata,
        input  addr_stall, resp_stall, mem_rdata,
        output addr_ok, addr_ok_addr, data_ok, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_en, req_wr, req_size, req_wen, req_addr, req_wdata,
        output addr_stall, resp_stall, mem_rdata,
        input  addr_ok, addr_ok_addr, data_ok, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_like_responder_resp_queue.sv
// In-order response store: slots are allocated at acceptance, filled one
// cycle later, and released from the head in allocation order.
module resp_queue #(
    parameter int DEPTH = 4,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          alloc,
    input  logic          cap_en,
    input  logic [PW-1:0] cap_slot,
    input  logic [31:0]   cap_data,
    input  logic          pop,
    output logic [PW-1:0] wr_ptr,
    output logic          full,
    output logic          head_ready,
    output logic [31:0]   head_data
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [DEPTH-1:0] ready_r;
    logic [31:0]   data_r [DEPTH];

    // Allocation and release pointers; DEPTH is a power of two so they wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (alloc) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
        end
    end

    // Occupancy: a same-cycle allocate and release cancel out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({alloc, pop})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Slot data and ready flags; the slot being filled is never the head being released.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (cap_en) begin
                data_r[cap_slot]  <= cap_data;
                ready_r[cap_slot] <= 1'b1;
            end
            if (pop) begin
                ready_r[rd_ptr_r] <= 1'b0;
            end
        end
    end

    // Head status for the response side.
    always_comb begin
        head_ready = ready_r[rd_ptr_r] && (count_r != {CW{1'b0}});
        head_data  = data_r[rd_ptr_r];
        full       = (count_r == DEPTH_C);
        wr_ptr     = wr_ptr_r;
    end

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like responder: accepts up to DEPTH pipelined requests, issues them to
// a synchronous memory and returns responses strictly in acceptance order.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic clk,
    input  logic resetn,
    sram_like_responder_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          accept_s;
    logic          data_ok_s;
    logic          full_s;
    logic          head_ready_s;
    logic [31:0]   head_data_s;
    logic [PW-1:0] wr_ptr_s;
    logic [31:0]   cap_data_s;
    logic          pend_valid_r;
    logic [PW-1:0] pend_slot_r;
    logic          pend_wr_r;
    size_e         unused_size_s;

    // Size is informational only: reads always return the full aligned word.
    assign unused_size_s = size_e'(bus.req_size);

    // Acceptance decision; fullness is judged before any same-cycle release.
    always_comb begin
        accept_s = 1'b0;
        if (resetn && bus.req_en && !bus.addr_stall && !full_s) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Acceptance handshake and memory command, both issued in the accepting cycle.
    always_comb begin
        bus.addr_ok      = 1'b0;
        bus.addr_ok_addr = 32'h0000_0000;
        bus.mem_en       = 1'b0;
        bus.mem_we       = 4'b0000;
        bus.mem_addr     = {AW{1'b0}};
        bus.mem_wdata    = 32'h0000_0000;
        if (accept_s) begin
            bus.addr_ok      = 1'b1;
            bus.addr_ok_addr = bus.req_addr;
            bus.mem_en       = 1'b1;
            bus.mem_we       = mem_we_f(bus.req_wr, bus.req_wen);
            bus.mem_addr     = bus.req_addr[AW+1:2];
            bus.mem_wdata    = bus.req_wdata;
        end else begin
            bus.addr_ok = 1'b0;
        end
    end

    // Pending register: remembers which slot receives next cycle's memory data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_valid_r <= 1'b0;
            pend_slot_r  <= {PW{1'b0}};
            pend_wr_r    <= 1'b0;
        end else begin
            pend_valid_r <= accept_s;
            if (accept_s) begin
                pend_slot_r <= wr_ptr_s;
                pend_wr_r   <= bus.req_wr;
            end
        end
    end

    // Writes complete with zero data; reads take the memory output.
    always_comb begin
        cap_data_s = 32'h0000_0000;
        if (pend_wr_r) begin
            cap_data_s = 32'h0000_0000;
        end else begin
            cap_data_s = bus.mem_rdata;
        end
    end

    // Response handshake from the queue head.
    always_comb begin
        data_ok_s = 1'b0;
        bus.data_ok = 1'b0;
        bus.rdata   = 32'h0000_0000;
        if (resetn && head_ready_s && !bus.resp_stall) begin
            data_ok_s   = 1'b1;
            bus.data_ok = 1'b1;
            bus.rdata   = head_data_s;
        end else begin
            data_ok_s = 1'b0;
        end
    end

    resp_queue #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_resp_queue (
        .clk        (clk),
        .resetn     (resetn),
        .alloc      (accept_s),
        .cap_en     (pend_valid_r),
        .cap_slot   (pend_slot_r),
        .cap_data   (cap_data_s),
        .pop        (data_ok_s),
        .wr_ptr     (wr_ptr_s),
        .full       (full_s),
        .head_ready (head_ready_s),
        .head_data  (head_data_s)
    );

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: directed scenarios plus randomized traffic,
// checked against an in-order transaction model with a shadow memory.
module tb_sram_like_responder;
    localparam int DEPTH = 4;
    localparam int AW    = 16;

    typedef struct {
        logic [31:0] data;
        int          acc_cycle;
    } exp_t;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;
    int   cycle;
    exp_t q[$];
    logic [31:0] env_mem [256];
    logic [31:0] ref_mem [256];

    sram_like_responder_if #(.AW(AW)) bus ();

    sram_like_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory: synchronous, byte-enabled, data valid the cycle after mem_en.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) env_mem[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            bus.mem_rdata <= env_mem[bus.mem_addr[7:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic step(input logic en, input logic wr, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic ast, input logic rstall,
                        output logic aok, output logic dok, output logic [31:0] rd);
        logic exp_aok;
        logic exp_dok;
        logic [31:0] exp_rd;
        exp_t e;
        int widx;
        @(negedge clk);
        resetn         = 1'b1;
        bus.req_en     = en;
        bus.req_wr     = wr;
        bus.req_wen    = wen;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_size   = 2'($urandom_range(0, 2));
        bus.addr_stall = ast;
        bus.resp_stall = rstall;
        #1;
        exp_aok = en && !ast && (q.size() < DEPTH);
        exp_dok = 1'b0;
        exp_rd  = 32'h0;
        if (q.size() > 0) begin
            if ((cycle >= q[0].acc_cycle + 2) && !rstall) begin
                exp_dok = 1'b1;
                exp_rd  = q[0].data;
            end
        end
        check_eq("addr_ok", 32'(bus.addr_ok), 32'(exp_aok));
        check_eq("data_ok", 32'(bus.data_ok), 32'(exp_dok));
        check_eq("rdata", bus.rdata, exp_rd);
        check_eq("mem_en", 32'(bus.mem_en), 32'(exp_aok));
        if (exp_aok) begin
            check_eq("addr_ok_addr", bus.addr_ok_addr, addr);
            check_eq("mem_addr", 32'(bus.mem_addr), 32'(addr[AW+1:2]));
            check_eq("mem_we", 32'(bus.mem_we), 32'(wr ? wen : 4'b0000));
            check_eq("mem_wdata", bus.mem_wdata, wdata);
        end else begin
            check_eq("addr_ok_addr_idle", bus.addr_ok_addr, 32'h0);
        end
        aok = bus.addr_ok;
        dok = bus.data_ok;
        rd  = bus.rdata;
        if (exp_dok) void'(q.pop_front());
        if (exp_aok) begin
            widx = int'(addr[9:2]);
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (wen[b]) ref_mem[widx][8*b +: 8] = wdata[8*b +: 8];
                end
                e.data = 32'h0;
            end else begin
                e.data = ref_mem[widx];
            end
            e.acc_cycle = cycle;
            q.push_back(e);
        end
        cycle++;
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        resetn         = 1'b0;
        bus.req_en     = 1'b1;
        bus.req_wr     = 1'b0;
        bus.req_addr   = 32'h0000_0044;
        bus.addr_stall = 1'b0;
        bus.resp_stall = 1'b0;
        #1;
        check_eq("rst_addr_ok", 32'(bus.addr_ok), 32'h0);
        check_eq("rst_data_ok", 32'(bus.data_ok), 32'h0);
        check_eq("rst_mem_en", 32'(bus.mem_en), 32'h0);
        check_eq("rst_rdata", bus.rdata, 32'h0);
        check_eq("rst_addr_ok_addr", bus.addr_ok_addr, 32'h0);
        q.delete();
        cycle++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic aok, dok;
        logic [31:0] rd;
        logic [31:0] fill_addr [5];
        int idx, first_dok, fifth_acc, ndok;

        n_checks = 0;
        n_errors = 0;
        cycle    = 0;
        resetn   = 1'b0;
        bus.req_en = 1'b0; bus.req_wr = 1'b0; bus.req_wen = 4'b0; bus.req_size = 2'b10;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus.addr_stall = 1'b0; bus.resp_stall = 1'b0; bus.mem_rdata = 32'h0;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        env_mem[16] = 32'hDEAD_BEEF;
        ref_mem[16] = 32'hDEAD_BEEF;

        reset_cycle();
        reset_cycle();

        // Single read, accepted in the first cycle out of reset.
        step(1'b1, 1'b0, 4'b0, 32'h40, 32'h0, 1'b0, 1'b0, aok, dok, rd);
        check_eq("rd1_aok", 32'(aok), 32'h1);
        step(1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, aok, dok, rd);
        check_eq("rd1_n1_dok", 32'(dok), 32'h0);
        step(1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, aok, dok, rd);
        check_eq("rd1_n2_dok", 32'(dok), 32'h1);
        check_eq("rd1_n2_rdata", rd, 32'hDEAD_BEEF);

        // Byte write then read-back.
        step(1'b1, 1'b1, 4'b0010, 32'h40, 32'h0000_AB00, 1'b0, 1'b0, aok, dok, rd);
        step(1'b1, 1'b0, 4'b1111, 32'h40, 32'h0, 1'b0, 1'b0, aok, dok, rd);
        step(1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, aok, dok, rd);
        check_eq("bw_wr_dok", 32'(dok), 32'h1);
        check_eq("bw_wr_rdata", rd, 32'h0);
        step(1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, aok, dok, rd);
        check_eq("bw_rd_dok", 32'(dok), 32'h1);
        check_eq("bw_rd_rdata", rd, 32'hDEAD_ABEF);

        // Fill under response stall, then drain.
        fill_addr[0] = 32'h0; fill_addr[1] = 32'h4; fill_addr[2] = 32'h8;
        fill_addr[3] = 32'hC; fill_addr[4] = 32'h10;
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 4'b0, fill_addr[idx], 32'h0, 1'b0, 1'b1, aok, dok, rd);
            if (aok) idx++;
        end
        check_eq("fill_accepts", 32'(idx), 32'd4);
        first_dok = -1; fifth_acc = -1; ndok = 0;
        for (int k = 0; k < 20; k++) begin
            step(idx < 5, 1'b0, 4'b0, fill_addr[idx < 5 ? idx : 4], 32'h0, 1'b0, 1'b0, aok, dok, rd);
            if (dok) begin
                ndok++;
                if (first_dok < 0) first_dok = k;
            end
            if (aok) begin
                if (idx == 4) fifth_acc = k;
                idx++;
            end
        end
        check_eq("fill_doks", 32'(ndok), 32'd5);
        check_eq("fill_fifth_gap", 32'(fifth_acc - first_dok), 32'd1);

        // Accept and release in the same cycle at count 2.
        step(1'b1, 1'b0, 4'b0, 32'h8, 32'h0, 1'b0, 1'b0, aok, dok, rd);
        step(1'b1, 1'b0, 4'b0, 32'hC, 32'h0, 1'b0, 1'b0, aok, dok, rd);
        step(1'b1, 1'b0, 4'b0, 32'h10, 32'h0, 1'b0, 1'b0, aok, dok, rd);
        check_eq("sim_aok", 32'(aok), 32'h1);
        check_eq("sim_dok", 32'(dok), 32'h1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, aok, dok, rd);

        // Acceptance stall.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 4'b0, 32'h20, 32'h0, 1'b1, 1'b0, aok, dok, rd);
            check_eq("astall_aok", 32'(aok), 32'h0);
        end
        step(1'b1, 1'b0, 4'b0, 32'h20, 32'h0, 1'b0, 1'b0, aok, dok, rd);
        check_eq("astall_release_aok", 32'(aok), 32'h1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, aok, dok, rd);

        // Reset with three requests in flight.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'b0, 32'(k * 4), 32'h0, 1'b0, 1'b1, aok, dok, rd);
        reset_cycle();
        ndok = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, aok, dok, rd);
            if (dok) ndok++;
        end
        check_eq("rstmid_doks", 32'(ndok), 32'd0);
        step(1'b1, 1'b0, 4'b0, 32'h40, 32'h0, 1'b0, 1'b0, aok, dok, rd);
        step(1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, aok, dok, rd);
        step(1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, aok, dok, rd);
        check_eq("rstmid_rd_dok", 32'(dok), 32'h1);
        check_eq("rstmid_rd_rdata", rd, 32'hDEAD_ABEF);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                reset_cycle();
            end else begin
                step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), 4'($urandom),
                     {$urandom_range(0, 255) == 0 ? 22'h3F_FFFF : 22'($urandom), 8'($urandom), 2'($urandom)},
                     $urandom, ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                     aok, dok, rd);
            end
        end
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, aok, dok, rd);
        check_eq("drain_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_like_responder.md
SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 Parameter DEPTH, default 4: maximum outstanding accepted-but-unanswered requests (power of two, 2..8).
REQ-002 Parameter AW, default 16: word-address width of the backing memory port.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 req_en  in  1  request valid from the initiator (fetch stage).
REQ-006 req_wr  in  1  1 = write, 0 = read.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word.
REQ-008 req_wen  in  4  byte write enables, used only when req_wr=1.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  write data.
REQ-011 addr_stall  in  1  external back-pressure on acceptance (bench/arbiter).
REQ-012 resp_stall  in  1  external back-pressure on response.
REQ-013 addr_ok  out  1  request accepted this cycle.
REQ-014 addr_ok_addr  out  32  byte address of the request accepted this cycle; 0 otherwise.
REQ-015 data_ok  out  1  oldest outstanding request completes this cycle.
REQ-016 rdata  out  32  read data for the completing request; 0 for writes.
REQ-017 mem_en / mem_we[4] / mem_addr[AW] / mem_wdata[32]  out: synchronous single-port memory command; mem_rdata[32] in, valid the cycle after mem_en.

Function
REQ-018 addr_ok SHALL equal req_en && !addr_stall && (count < DEPTH); combinational, no dependence on a same-cycle data_ok.
REQ-019 On acceptance, the block SHALL drive mem_en=1, mem_addr=req_addr[AW+1:2], mem_wdata=req_wdata, mem_we=req_wr ? req_wen : 4'b0 in the same cycle; mem_en=0 otherwise.
REQ-020 On acceptance, the block SHALL allocate the slot at wr_ptr, increment wr_ptr (mod DEPTH) and count, and set a pending register {valid, slot, wr}.
REQ-021 In the cycle after acceptance, the slot SHALL capture mem_rdata (read) or 32'b0 (write) and the slot becomes ready; pending may be re-armed by a new acceptance in that same cycle.
REQ-022 data_ok SHALL equal (head slot ready) && !resp_stall; rdata = head slot data when data_ok, else 0.
REQ-023 On data_ok, rd_ptr SHALL increment (mod DEPTH) and count decrement; simultaneous accept and data_ok SHALL leave count unchanged.
REQ-024 Responses SHALL be returned strictly in acceptance order; no request is ever dropped or reordered.
REQ-025 Minimum latency: accept in cycle N -> data_ok no earlier than cycle N+2; back-to-back acceptance, one per cycle, SHALL be sustained while count < DEPTH.
REQ-026 Full: with count == DEPTH, addr_ok=0 even if data_ok fires this cycle; acceptance resumes the next cycle.
REQ-027 Empty: with count == 0 or head not ready, data_ok=0 regardless of resp_stall.
REQ-028 req_size is not checked against req_addr alignment; read data is always the full aligned word.
REQ-029 addr_ok_addr SHALL equal req_addr when addr_ok=1, so the initiator can match acceptance to its current address.

Reset
REQ-030 While resetn=0: count=0, wr_ptr=rd_ptr=0, pending.valid=0, all slot-ready flags 0; addr_ok, data_ok and mem_en held 0; rdata and addr_ok_addr 0.
REQ-031 Reset asserted mid-operation SHALL discard all outstanding requests immediately; no data_ok for them after release.
REQ-032 The first acceptance SHALL be possible in the first clock cycle after resetn deasserts.

Structure
REQ-033 The shared package SHALL hold the size encodings (SIZE_B, SIZE_H, SIZE_W) and the default DEPTH.
REQ-034 Response storage SHALL be one sub-module, resp_queue (slot-addressed write, head read, ready flags, pointers, count); the top level holds acceptance logic and the pending register.

Verification
REQ-035 Single read: memory word 0x10 = 0xDEADBEEF; req read addr 0x40 at cycle 0 -> addr_ok=1 and addr_ok_addr=0x40 at cycle 0; data_ok=1 and rdata=0xDEADBEEF at cycle 2.
REQ-036 Byte write then read: write wen=4'b0010, wdata=0x0000AB00 to 0x40, then read 0x40 -> write data_ok has rdata=0; read returns 0xDEADABEF.
REQ-037 Fill: resp_stall=1, req_en held high with addresses 0x0, 0x4, 0x8, 0xC, 0x10 -> four addr_ok, fifth blocked; release resp_stall -> four data_ok in order, then fifth accepted the cycle after the first data_ok.
REQ-038 Simultaneous: count=2, accept and data_ok in the same cycle -> count stays 2, order preserved.
REQ-039 addr_stall=1 for 3 cycles with req_en=1 -> no mem_en, no addr_ok; accepted on the first cycle addr_stall=0.
REQ-040 Reset mid-flight: 3 requests outstanding, pulse resetn low for 1 cycle -> no data_ok afterwards; a new read returns the correct data at N+2.
